sum_arb: RTL and testbench
==========================

SUM_ARB -- requirements
Module: sum_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of data elements and of the result.
REQ-002 Parameter N_W, default 8, width of element-count field.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  2  per-requester job request; held high until that requester's done_o pulse.
REQ-006 n_i  input  2xN_W  per-requester element count; valid while req_i is high.
REQ-007 data_i  input  2xDATA_W  per-requester element stream; the element is consumed when rdy_o is high.
REQ-008 gnt_o  output  2  one-hot grant; high for the whole job.
REQ-009 rdy_o  output  2  element-accept strobe to the granted requester.
REQ-010 done_o  output  2  one-cycle job-complete pulse to the granted requester.
REQ-011 res_o  output  DATA_W  last captured sum; held until the next capture.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 eng_start_o, eng_n_o[N_W], eng_data_o[DATA_W]  outputs  drive the shared accumulator engine.
REQ-014 eng_done_i  input  1 and eng_sum_i  input  DATA_W  engine completion flag and result.
REQ-015 eng_clr_no  output  1  active-low engine re-arm; low for exactly one cycle per job.

Function
REQ-016 The FSM SHALL have states IDLE, START, STREAM, WAIT, CLEAR.
REQ-017 IDLE: with any req_i set, SHALL grant round-robin, preferring the requester not granted last; after reset requester 0 is preferred; SHALL latch that requester's n_i; next state START.
REQ-018 IDLE with req_i=0 SHALL remain IDLE with all strobes low.
REQ-019 START: eng_start_o=1 and eng_n_o=latched n for exactly one cycle; next STREAM if n>0, else WAIT.
REQ-020 STREAM: rdy_o[g]=1 and eng_data_o=data_i[g] every cycle; an N_W-bit counter increments from 0; after the cycle with count n-1, next state WAIT; exactly n elements consumed.
REQ-021 Outside STREAM, eng_data_o SHALL be 0 and rdy_o SHALL be 0.
REQ-022 WAIT: on eng_done_i=1, res_o<=eng_sum_i, done_o[g] pulses for one cycle, and the next state is CLEAR.
REQ-023 WAIT SHALL time out after 255 cycles without eng_done_i; it then proceeds as a completion with res_o<=0.
REQ-024 CLEAR: eng_clr_no=0 for one cycle; gnt_o drops; next IDLE; the earliest re-grant is the following cycle.
REQ-025 gnt_o SHALL stay constant from START through CLEAR; request changes during a job SHALL be ignored.
REQ-026 Sum arithmetic belongs to the engine; res_o SHALL pass eng_sum_i unmodified (modulo 2^DATA_W).
REQ-027 Simultaneous requests: only one grant per job; the loser SHALL be served next, regardless of re-assertion by the winner.

Reset
REQ-028 Asynchronous reset (rst_ni low) SHALL immediately force IDLE; gnt_o, rdy_o, done_o, res_o, eng_start_o, eng_n_o, eng_data_o, counters = 0; busy_o=0; eng_clr_no=0 while rst_ni low; round-robin pointer to prefer requester 0.
REQ-029 Reset mid-job SHALL abandon the job with no done_o pulse; the first job after release starts from IDLE.

Verification
REQ-030 Single job: req_i=01, n=3, data 5,6,7, engine returns 18 -> start pulse 1 cycle after grant, rdy_o[0] high 3 cycles, done_o=01 pulse, res_o=18.
REQ-031 Contention: req_i=11 from IDLE -> requester 0 served first, then requester 1; with 0 re-requesting, 1 still wins the next arbitration.
REQ-032 n=0: START -> WAIT directly, rdy_o never high, engine result (0) captured, done pulse.
REQ-033 Timeout: eng_done_i held 0 -> done_o pulse 255 cycles after WAIT entry, res_o=0, eng_clr_no low 1 cycle.
REQ-034 Overflow: n=2, data 200,100, engine returns 44 -> res_o=44.
REQ-035 Reset asserted in STREAM -> all outputs 0 asynchronously, no done_o; the next job completes normally.

Source files
------------

// File: rtl/sum_arb.sv
// rtl/sum_arb.sv - two-requester round-robin front end for a shared accumulator engine
module sum_arb #(
    parameter int DATA_W = 8,
    parameter int N_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_i,
    input  logic [2*N_W-1:0]    n_i,
    input  logic [2*DATA_W-1:0] data_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rdy_o,
    output logic [1:0]          done_o,
    output logic [DATA_W-1:0]   res_o,
    output logic                busy_o,
    output logic                eng_start_o,
    output logic [N_W-1:0]      eng_n_o,
    output logic [DATA_W-1:0]   eng_data_o,
    input  logic                eng_done_i,
    input  logic [DATA_W-1:0]   eng_sum_i,
    output logic                eng_clr_no
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'd254;

    logic [2:0]     state;
    logic           prio;
    logic           gidx;
    logic           pick;
    logic [N_W-1:0] n_lat;
    logic [N_W-1:0] cnt;
    logic [N_W-1:0] n_last;
    logic [7:0]     wcnt;

    // Preferred requester wins if asking, otherwise the other one
    assign pick   = req_i[prio] ? prio : ~prio;
    assign n_last = n_lat - {{(N_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            prio   <= 1'b0;
            gidx   <= 1'b0;
            gnt_o  <= 2'b00;
            done_o <= 2'b00;
            res_o  <= '0;
            n_lat  <= '0;
            cnt    <= '0;
            wcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        gnt_o <= pick ? 2'b10 : 2'b01;
                        gidx  <= pick;
                        prio  <= ~pick;
                        n_lat <= pick ? n_i[2*N_W-1:N_W] : n_i[N_W-1:0];
                        state <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    wcnt  <= '0;
                    state <= (n_lat != '0) ? STREAM : WAIT;
                end
                STREAM: begin
                    if (cnt == n_last) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // The 255th idle WAIT cycle completes the job with a zero result
                    if (eng_done_i) begin
                        res_o  <= eng_sum_i;
                        done_o <= gnt_o;
                        state  <= CLEAR;
                    end else if (wcnt == WAIT_LAST) begin
                        res_o  <= '0;
                        done_o <= gnt_o;
                        state  <= CLEAR;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                CLEAR: begin
                    done_o <= 2'b00;
                    gnt_o  <= 2'b00;
                    wcnt   <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdy_o       = (state == STREAM) ? gnt_o : 2'b00;
    assign eng_data_o  = (state == STREAM) ? (gidx ? data_i[2*DATA_W-1:DATA_W] : data_i[DATA_W-1:0]) : '0;
    assign eng_start_o = (state == START);
    assign eng_n_o     = (state == START) ? n_lat : '0;
    assign busy_o      = (state != IDLE);
    assign eng_clr_no  = rst_ni && (state != CLEAR);

endmodule

// File: tb/tb_sum_arb.sv
// tb/tb_sum_arb.sv - directed vector bench for sum_arb
module tb_sum_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [15:0] n_i;
    logic [15:0] data_i;
    logic [1:0]  gnt_o, rdy_o, done_o;
    logic [7:0]  res_o;
    logic        busy_o, eng_start_o;
    logic [7:0]  eng_n_o, eng_data_o;
    logic        eng_done_i;
    logic [7:0]  eng_sum_i;
    logic        eng_clr_no;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sum_arb #(.DATA_W(8), .N_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .n_i(n_i), .data_i(data_i),
        .gnt_o(gnt_o), .rdy_o(rdy_o), .done_o(done_o), .res_o(res_o), .busy_o(busy_o),
        .eng_start_o(eng_start_o), .eng_n_o(eng_n_o), .eng_data_o(eng_data_o),
        .eng_done_i(eng_done_i), .eng_sum_i(eng_sum_i), .eng_clr_no(eng_clr_no)
    );

    typedef struct packed {
        logic [1:0]  req;
        int          g;
        logic [7:0]  n;
        logic [31:0] data;   // element k in bits [8k+7:8k]
        logic [7:0]  sum;
        int          dly;    // -1: engine never answers
        logic [7:0]  exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        logic [1:0]  g_oh;
        logic [31:0] d;
        int k;
        int c;
        bit done_seen;
        g_oh = (v.g == 1) ? 2'b10 : 2'b01;
        d    = v.data;
        req_i  = v.req;
        n_i    = {v.n, v.n};
        data_i = {d[7:0], d[7:0]};
        tick();
        chk("start_gnt", {30'd0, gnt_o}, {30'd0, g_oh});
        chk("start_pulse", {31'd0, eng_start_o}, 32'd1);
        chk("start_n", {24'd0, eng_n_o}, {24'd0, v.n});
        chk("start_busy", {31'd0, busy_o}, 32'd1);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdy_o == 2'b00) break;
            chk("rdy", {30'd0, rdy_o}, {30'd0, g_oh});
            chk("eng_data", {24'd0, eng_data_o}, {24'd0, d[7:0]});
            k++;
            d      = d >> 8;
            data_i = {d[7:0], d[7:0]};
        end
        chk("elem_count", k, {24'd0, v.n});
        chk("wait_data_zero", {24'd0, eng_data_o}, 32'd0);
        chk("wait_gnt", {30'd0, gnt_o}, {30'd0, g_oh});
        if (v.dly >= 0) begin
            for (int i = 0; i < v.dly; i++) tick();
            eng_done_i = 1'b1;
            eng_sum_i  = v.sum;
            tick();
            eng_done_i = 1'b0;
        end else begin
            c = 0;
            done_seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tick();
                c++;
                if (done_o != 2'b00) begin
                    done_seen = 1'b1;
                    break;
                end
            end
            chk("timeout_seen", {31'd0, done_seen}, 32'd1);
            chk("timeout_cycles", c, 32'd255);
        end
        chk("done_pulse", {30'd0, done_o}, {30'd0, g_oh});
        chk("res", {24'd0, res_o}, {24'd0, v.exp_res});
        chk("clr_low", {31'd0, eng_clr_no}, 32'd0);
        chk("clear_gnt", {30'd0, gnt_o}, {30'd0, g_oh});
        req_i = 2'b00;
        tick();
        chk("idle_gnt", {30'd0, gnt_o}, 32'd0);
        chk("idle_done", {30'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_clr", {31'd0, eng_clr_no}, 32'd1);
        chk("res_hold", {24'd0, res_o}, {24'd0, v.exp_res});
    endtask

    initial begin
        vecs[0] = '{req: 2'b01, g: 0, n: 8'd3, data: 32'h00070605, sum: 8'd18, dly: 1,  exp_res: 8'd18};
        vecs[1] = '{req: 2'b10, g: 1, n: 8'd2, data: 32'h000064C8, sum: 8'd44, dly: 0,  exp_res: 8'd44};
        vecs[2] = '{req: 2'b11, g: 0, n: 8'd1, data: 32'h00000009, sum: 8'd9,  dly: 3,  exp_res: 8'd9};
        vecs[3] = '{req: 2'b11, g: 1, n: 8'd0, data: 32'h00000000, sum: 8'd0,  dly: 0,  exp_res: 8'd0};
        vecs[4] = '{req: 2'b11, g: 0, n: 8'd4, data: 32'h04030201, sum: 8'd10, dly: 0,  exp_res: 8'd10};
        vecs[5] = '{req: 2'b11, g: 1, n: 8'd1, data: 32'h00000055, sum: 8'h55, dly: -1, exp_res: 8'd0};
        vecs[6] = '{req: 2'b01, g: 0, n: 8'd2, data: 32'h00000302, sum: 8'd5,  dly: 2,  exp_res: 8'd5};

        rst_ni = 1'b0; req_i = 2'b00; n_i = '0; data_i = '0;
        eng_done_i = 1'b0; eng_sum_i = '0;
        #1;
        chk("rst_clr", {31'd0, eng_clr_no}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("reset_gnt", {30'd0, gnt_o}, 32'd0);
        chk("reset_res", {24'd0, res_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_clr", {31'd0, eng_clr_no}, 32'd1);
        tick();
        chk("idle_noreq_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_noreq_start", {31'd0, eng_start_o}, 32'd0);

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Reset in the middle of a stream: outputs clear at once, no done pulse
        req_i = 2'b10; n_i = {8'd4, 8'd4}; data_i = 16'h0303;
        tick();
        tick();
        chk("pre_rst_rdy", {30'd0, rdy_o}, 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_gnt", {30'd0, gnt_o}, 32'd0);
        chk("async_rdy", {30'd0, rdy_o}, 32'd0);
        chk("async_res", {24'd0, res_o}, 32'd0);
        chk("async_busy", {31'd0, busy_o}, 32'd0);
        chk("async_data", {24'd0, eng_data_o}, 32'd0);
        chk("async_clr", {31'd0, eng_clr_no}, 32'd0);
        tick();
        chk("rst_no_done", {30'd0, done_o}, 32'd0);
        rst_ni = 1'b1;
        req_i  = 2'b00;
        tick();
        run_job('{req: 2'b11, g: 0, n: 8'd2, data: 32'h00000201, sum: 8'd3, dly: 0, exp_res: 8'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
